// File: rtl/timer_entry_loader.sv
// rtl/timer_entry_loader.sv - keypad MM:SS entry, validation and load/enable sequencing for the countdown chain
//
// Collects BCD key digits into an MM:SS preset. Drives the cascaded down-counters
// with a one-cycle active-low parallel load followed by a count enable. Watches
// the chain's zero flag to finish a cook cycle, and handles pause and cancel.
//
// Optional feature macro: QUICK_START_EN
//   defined   - start in IDLE with all digits zero loads a 00:30 preset and runs it
//   undefined - that start is rejected with an entry_error pulse
//
// Ports:
//   clock        in   system clock, rising edge
//   clearn       in   synchronous active-low reset
//   key          in   BCD key code
//   key_valid    in   one-cycle strobe qualifying key
//   start        in   start / resume request (level)
//   stop         in   pause / cancel request (level)
//   zero_in      in   counter chain reads 0000
//   data         out  preset digits, digit i at [4i+3:4i]
//   loadn        out  active-low parallel load to the counters
//   enable       out  count enable to the counters
//   busy         out  high in LOAD, RUN, PAUSE
//   done         out  one-cycle pulse when a cook cycle reaches zero
//   entry_error  out  one-cycle pulse on a rejected key or start
module timer_entry_loader #(
    parameter int NDIG         = 4,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic              clock,
    input  logic              clearn,
    input  logic [3:0]        key,
    input  logic              key_valid,
    input  logic              start,
    input  logic              stop,
    input  logic              zero_in,
    output logic [4*NDIG-1:0] data,
    output logic              loadn,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic              entry_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [3:0]        SEC_TENS_LIM = 4'(SEC_TENS_MAX);
    localparam logic [4*NDIG-1:0] DIGITS_ZERO  = '0;
`ifdef QUICK_START_EN
    // 00:30 - seconds tens digit set to 3, everything else zero
    localparam logic [4*NDIG-1:0] QUICK_PRESET = {{(4*NDIG-8){1'b0}}, 8'h30};
`endif

    state_t            state_q;
    logic [4*NDIG-1:0] digits_q;
    logic              loadn_q;
    logic              enable_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              digits_zero;
    logic              start_ok;

    assign digits_zero = (digits_q == DIGITS_ZERO);
    assign start_ok    = !digits_zero && (digits_q[7:4] <= SEC_TENS_LIM);

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state_q  <= IDLE;
            digits_q <= '0;
            loadn_q  <= 1'b1;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Pulses and the load strobe default to inactive every cycle
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            loadn_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (stop) begin
                        digits_q <= '0;
                    end else if (start) begin
                        // Evaluated on the pre-shift digits; a same-cycle key is dropped
                        if (start_ok) begin
                            state_q <= LOAD;
                            loadn_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
`ifdef QUICK_START_EN
                        else if (digits_zero) begin
                            digits_q <= QUICK_PRESET;
                            state_q  <= LOAD;
                            loadn_q  <= 1'b0;
                            busy_q   <= 1'b1;
                        end
`endif
                        else begin
                            err_q <= 1'b1;
                        end
                    end else if (key_valid) begin
                        if (key <= 4'd9) begin
                            digits_q <= {digits_q[4*NDIG-5:0], key};
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Counters take the preset on this edge; counting starts next cycle
                    state_q  <= RUN;
                    enable_q <= 1'b1;
                end
                RUN: begin
                    if (zero_in) begin
                        state_q  <= IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        digits_q <= '0;
                        done_q   <= 1'b1;
                    end else if (stop) begin
                        state_q  <= PAUSE;
                        enable_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        digits_q <= '0;
                    end else if (start) begin
                        state_q  <= RUN;
                        enable_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data        = digits_q;
    assign loadn       = loadn_q;
    assign enable      = enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign entry_error = err_q;

endmodule

// File: tb/tb_timer_entry_loader.sv
// tb/tb_timer_entry_loader.sv - directed table-driven bench for timer_entry_loader
module tb_timer_entry_loader;

    logic        clock = 1'b0;
    logic        clearn;
    logic [3:0]  key;
    logic        key_valid;
    logic        start;
    logic        stop;
    logic        zero_in;
    logic [15:0] data;
    logic        loadn;
    logic        enable;
    logic        busy;
    logic        done;
    logic        entry_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    timer_entry_loader #(.NDIG(4), .SEC_TENS_MAX(5)) dut (
        .clock       (clock),
        .clearn      (clearn),
        .key         (key),
        .key_valid   (key_valid),
        .start       (start),
        .stop        (stop),
        .zero_in     (zero_in),
        .data        (data),
        .loadn       (loadn),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .entry_error (entry_error)
    );

    typedef struct {
        logic        rn;
        logic [3:0]  k;
        logic        kv;
        logic        st;
        logic        sp;
        logic        z;
        logic [15:0] d;
        logic        ln;
        logic        en;
        logic        bz;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rn, input logic [3:0] k, input logic kv,
                                input logic st, input logic sp, input logic z,
                                input logic [15:0] d, input logic ln, input logic en,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.rn = rn; v.k = k; v.kv = kv; v.st = st; v.sp = sp; v.z = z;
        v.d = d; v.ln = ln; v.en = en; v.bz = bz; v.dn = dn; v.er = er;
        return v;
    endfunction

    task automatic drive(input logic rn, input logic [3:0] k, input logic kv,
                         input logic st, input logic sp, input logic z);
        clearn = rn; key = k; key_valid = kv; start = st; stop = sp; zero_in = z;
    endtask

    // Advance one edge and sample 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
        n_checks++;
        if (!loadn && enable) begin
            n_fail++;
            $display("FAIL load_enable_overlap: loadn=%b enable=%b required not both active", loadn, enable);
        end
        n_checks++;
        if (done && entry_error) begin
            n_fail++;
            $display("FAIL done_error_overlap: done=%b entry_error=%b required not both high", done, entry_error);
        end
    endtask

    task automatic check(input string name, input logic [15:0] d, input logic ln,
                         input logic en, input logic bz, input logic dn, input logic er);
        n_checks++;
        if ({data, loadn, enable, busy, done, entry_error} !== {d, ln, en, bz, dn, er}) begin
            n_fail++;
            $display("FAIL %s: got data=%h loadn=%b enable=%b busy=%b done=%b err=%b, required data=%h loadn=%b enable=%b busy=%b done=%b err=%b",
                     name, data, loadn, enable, busy, done, entry_error, d, ln, en, bz, dn, er);
        end
    endtask

    initial begin
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        //                rn key  kv st sp z   data      ln en bz dn er
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 4'h1, 1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 1, 0, 0, 0, 16'h0013, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0, 16'h0130, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h0130, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0130, 0, 0, 1, 0, 0)); // LOAD
        tbl.push_back(mk(1, 4'h5, 1, 1, 1, 1, 16'h0130, 1, 1, 1, 0, 0)); // LOAD ignores all
        tbl.push_back(mk(1, 4'h7, 1, 1, 0, 0, 16'h0130, 1, 1, 1, 0, 0)); // RUN ignores key/start
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 1, 0)); // zero -> done
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 0, 16'h0002, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 1, 0, 0, 0, 16'h0025, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0025, 0, 0, 1, 0, 0)); // LOAD
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h0025, 1, 1, 1, 0, 0)); // RUN
        tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 16'h0025, 1, 0, 1, 0, 0)); // PAUSE
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 1, 16'h0025, 1, 0, 1, 0, 0)); // zero ignored
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0025, 1, 1, 1, 0, 0)); // resume, no load
        tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 16'h0025, 1, 0, 1, 0, 0)); // PAUSE
        tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 0)); // cancel
        tbl.push_back(mk(1, 4'h1, 1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0001, 0, 0, 1, 0, 0)); // LOAD
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h0001, 1, 1, 1, 0, 0)); // RUN
        tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 16'h0001, 1, 0, 1, 0, 0)); // PAUSE
        tbl.push_back(mk(1, 4'h0, 0, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 0)); // start+stop -> cancel
        tbl.push_back(mk(1, 4'h4, 1, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 1, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 1)); // bad key
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h7, 1, 0, 0, 0, 16'h0047, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0, 16'h0470, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0470, 1, 0, 0, 0, 1)); // sec tens 7 rejected
        tbl.push_back(mk(1, 4'h1, 1, 1, 0, 0, 16'h0470, 1, 0, 0, 0, 1)); // key dropped with start
        tbl.push_back(mk(1, 4'h0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 0)); // stop clears
`ifdef QUICK_START_EN
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0030, 0, 0, 1, 0, 0)); // quick start
`else
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 1)); // zero preset rejected
`endif
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 4'h1, 1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 0, 16'h0012, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 1, 0, 0, 0, 16'h0123, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 1, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 1, 0, 0, 0, 16'h2345, 1, 0, 0, 0, 0)); // top digit dropped
        tbl.push_back(mk(1, 4'h9, 1, 0, 0, 0, 16'h3459, 1, 0, 0, 0, 0)); // sec tens 5 boundary
        tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 16'h3459, 0, 0, 1, 0, 0)); // accepted
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h3459, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 16'h3459, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0)); // reset mid-RUN

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].k, tbl[i].kv, tbl[i].st, tbl[i].sp, tbl[i].z);
            tick();
            check($sformatf("vec%0d", i), tbl[i].d, tbl[i].ln, tbl[i].en, tbl[i].bz, tbl[i].dn, tbl[i].er);
        end

        // Reset asserted in the cycle loadn is low
        drive(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("lr_key", 16'h0004, 1, 0, 0, 0, 0);
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("lr_load", 16'h0004, 0, 0, 1, 0, 0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("lr_reset", 16'h0000, 1, 0, 0, 0, 0);

        // Run a preset and wait, bounded, for done after zero_in rises
        drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("cd_load", 16'h0003, 0, 0, 1, 0, 0);
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("cd_run%0d", c), 16'h0003, 1, 1, 1, 0, 0);
        end
        zero_in = 1'b1;
        begin
            int budget;
            budget = 0;
            do begin
                tick();
                budget++;
            end while (!done && budget < 10);
            n_checks++;
            if (!done) begin
                n_fail++;
                $display("FAIL cd_done_timeout: done=%b after %0d cycles, required done=1", done, budget);
            end else if (budget != 1) begin
                n_fail++;
                $display("FAIL cd_done_latency: done after %0d cycles, required 1", budget);
            end
        end
        check("cd_done", 16'h0000, 1, 0, 0, 1, 0);
        zero_in = 1'b0;
        tick();
        check("cd_after", 16'h0000, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
